// File: rtl/argmax_stream_reducer.sv
// argmax_stream_reducer
//   Reduces a stream of per-beat (max value, local index) pairs coming out of
//   the combinational max tree into a single global maximum and its flat
//   index {beat_number, local_index}. The reduction length is set per run.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle pulse, begins a reduction (honoured only in IDLE)
//   num_beats  beats in this reduction, latched on start; 0 means MAX_BEATS
//   in_valid   beat valid
//   in_ready   high while accumulating
//   in_max     beat maximum value (unsigned)
//   in_idx     beat local index
//   out_valid  result valid, held until out_ready
//   out_ready  consumer ready
//   out_max    global maximum
//   out_idx    global index {beat, local}
//   busy       high while accumulating or holding a result
module argmax_stream_reducer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_DATA   = 16,
   parameter int MAX_BEATS  = 64,
   localparam int LIDX_W    = $clog2(NUM_DATA),
   localparam int BEAT_W    = $clog2(MAX_BEATS),
   localparam int GIDX_W    = LIDX_W + BEAT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BEAT_W-1:0]     num_beats,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_max,
   input  logic [LIDX_W-1:0]     in_idx,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_max,
   output logic [GIDX_W-1:0]     out_idx,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   logic [BEAT_W-1:0] beat_cnt;
   // Total is one bit wider than the counter so MAX_BEATS is representable.
   logic [BEAT_W:0]   total;
   logic [BEAT_W:0]   total_m1;
   logic              last_beat;

   assign total_m1  = total - 1'b1;
   assign last_beat = ({1'b0, beat_cnt} == total_m1);

   // out_max / out_idx double as the running max / index, so they hold their
   // final value through DONE and into IDLE without extra copies.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_max   <= '0;
         out_idx   <= '0;
         beat_cnt  <= '0;
         total     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  total    <= (num_beats == '0) ? (BEAT_W+1)'(MAX_BEATS)
                                                : {1'b0, num_beats};
                  beat_cnt <= '0;
                  state    <= ACCUM;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  // First beat loads unconditionally; later beats need a
                  // strictly larger value so ties keep the earlier beat.
                  if (beat_cnt == '0 || in_max > out_max) begin
                     out_max <= in_max;
                     out_idx <= {beat_cnt, in_idx};
                  end
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_beat) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
